// File: rtl/result_collector_pkg.sv
// Shared constants for the result collector: default parameters and the
// saturation limit of the drop counter.
package result_collector_pkg;

    localparam int DEF_DATA_W = 7;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DROP_CNT_W = 8;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage : result_collector_pkg

// File: rtl/result_fifo.sv
// First-word fall-through FIFO: storage, wrapping pointers and occupancy.
// The storage array is never reset; only pointers and level are.
module result_fifo
    import result_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Pointer and occupancy next-state; clear beats any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents survive reset and clear on purpose.
    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Head word is presented combinationally (fall-through).
    always_comb begin
        rd_data = mem[rd_ptr_q];
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        level   = level_q;
    end

endmodule : result_fifo

// File: rtl/result_collector.sv
// Collects adder results into a FWFT FIFO, keeps a saturating running sum of
// accepted words, and counts words dropped because the FIFO was full.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_c,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [ACC_W-1:0]         acc_sum,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    output logic                     overflow
);

    logic push;
    logic pop;
    logic drop;
    logic [ACC_W:0] acc_wide;

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  overflow_q, overflow_d;

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (push),
        .rd_en   (pop),
        .wr_data (in_c),
        .rd_data (out_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // Handshake decode: a full FIFO still accepts when the head leaves the
    // same cycle; clear suppresses every transfer and every drop.
    always_comb begin
        out_valid = !empty;
        pop       = out_valid && out_ready && !clear;
        push      = in_valid && !clear && (!full || pop);
        drop      = in_valid && !clear && !push;
    end

    // Running sum, drop counter and sticky overflow next-state.
    always_comb begin
        acc_d      = acc_q;
        drop_cnt_d = drop_cnt_q;
        overflow_d = overflow_q;
        acc_wide   = {1'b0, acc_q} + (ACC_W + 1)'(in_c);
        if (clear) begin
            acc_d      = '0;
            drop_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                acc_d = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != DROP_CNT_MAX) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    // Statistics registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Expose statistics registers.
    always_comb begin
        acc_sum  = acc_q;
        drop_cnt = drop_cnt_q;
        overflow = overflow_q;
    end

endmodule : result_collector
